// File: rtl/gate_count_ctrl.sv
// gate_count_ctrl: gated pulse-count sequencer for a 3-digit BCD counter datapath
// Ports: clk/rst (async high) | start_i, cont_i, abort_i control | num_i pulse input
//        cnt_bcd_i/cnt_of_i live datapath value | cnt_clr_o/cnt_inc_o datapath control
//        res_bcd_o/res_of_o/res_stb_o latched result | busy_o, state_o status
// Option: GATE_OVF_STOP_EN ends the gate window early on datapath overflow.
`timescale 1ns/1ps
module gate_count_ctrl #(
  parameter int GATE_CYCLES = 1000,
  parameter int HOLD_CYCLES = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        cont_i,
  input  logic        abort_i,
  input  logic        num_i,
  input  logic [11:0] cnt_bcd_i,
  input  logic        cnt_of_i,
  output logic        cnt_clr_o,
  output logic        cnt_inc_o,
  output logic [11:0] res_bcd_o,
  output logic        res_of_o,
  output logic        res_stb_o,
  output logic        busy_o,
  output logic [2:0]  state_o
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, CLEAR = 3'd1, GATE = 3'd2, SETTLE = 3'd3, LATCH = 3'd4, HOLD = 3'd5
  } state_t;
  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [GW-1:0] G_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  state_t state_q, state_d;
  logic [GW-1:0] gate_q, gate_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [11:0] res_bcd_q, res_bcd_d;
  logic res_of_q, res_of_d, res_stb_q, res_stb_d, num_q, ovf_stop;
`ifdef GATE_OVF_STOP_EN
  assign ovf_stop = cnt_of_i;
`else
  assign ovf_stop = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gate_q    <= '0;
      hold_q    <= '0;
      res_bcd_q <= '0;
      res_of_q  <= 1'b0;
      res_stb_q <= 1'b0;
      num_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      hold_q    <= hold_d;
      res_bcd_q <= res_bcd_d;
      res_of_q  <= res_of_d;
      res_stb_q <= res_stb_d;
      num_q     <= num_i;
    end
  end
  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    hold_d    = hold_q;
    res_bcd_d = res_bcd_q;
    res_of_d  = res_of_q;
    res_stb_d = 1'b0;
    if (abort_i && state_q != IDLE) state_d = IDLE;
    else case (state_q)
      IDLE:   state_d = start_i ? CLEAR : IDLE;
      CLEAR: begin
        gate_d  = '0;
        state_d = GATE;
      end
      GATE: begin
        gate_d  = gate_q + 1'b1;
        state_d = (gate_q == G_LAST || ovf_stop) ? SETTLE : GATE;
      end
      SETTLE: state_d = LATCH;
      LATCH: begin
        res_bcd_d = cnt_bcd_i;
        res_of_d  = cnt_of_i;
        res_stb_d = 1'b1;
        hold_d    = '0;
        state_d   = cont_i ? HOLD : IDLE;
      end
      HOLD: begin
        hold_d  = hold_q + 1'b1;
        state_d = (hold_q == H_LAST) ? (cont_i ? CLEAR : IDLE) : HOLD;
      end
      default: state_d = IDLE;
    endcase
  end
  // abort suppresses the increment in the cycle it takes effect
  assign cnt_inc_o = (state_q == GATE) & num_i & ~num_q & ~abort_i;
  assign cnt_clr_o = (state_q == CLEAR);
  assign res_bcd_o = res_bcd_q;
  assign res_of_o  = res_of_q;
  assign res_stb_o = res_stb_q;
  assign busy_o    = (state_q != IDLE);
  assign state_o   = state_q;
endmodule

// File: tb/tb_gate_count_ctrl.sv
// tb_gate_count_ctrl: directed self-checking bench for gate_count_ctrl with a behavioural BCD counter
`timescale 1ns/1ps
module tb_gate_count_ctrl;
  logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, cont_i = 1'b0, abort_i = 1'b0, num_i = 1'b0;
  logic of_force = 1'b0, tog = 1'b0;
  logic [11:0] bcd_m, res_bcd_o;
  logic cnt_clr_o, cnt_inc_o, res_of_o, res_stb_o, busy_o;
  logic [2:0] state_o;
  int nchk = 0, nerr = 0, n_clr = 0, n_inc = 0, n_stb = 0, lat, b_clr, b_inc, b_stb;
  gate_count_ctrl #(.GATE_CYCLES(20), .HOLD_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cont_i(cont_i), .abort_i(abort_i),
    .num_i(num_i), .cnt_bcd_i(bcd_m), .cnt_of_i(of_force), .cnt_clr_o(cnt_clr_o),
    .cnt_inc_o(cnt_inc_o), .res_bcd_o(res_bcd_o), .res_of_o(res_of_o),
    .res_stb_o(res_stb_o), .busy_o(busy_o), .state_o(state_o)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] h, t, u;
    {h, t, u} = v;
    if (u == 4'd9) begin
      u = 4'd0;
      if (t == 4'd9) begin
        t = 4'd0;
        h = (h == 4'd9) ? 4'd0 : h + 4'd1;
      end else t = t + 4'd1;
    end else u = u + 4'd1;
    return {h, t, u};
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) bcd_m <= '0;
    else if (cnt_clr_o) bcd_m <= '0;
    else if (cnt_inc_o) bcd_m <= bcd_inc(bcd_m);
  always @(posedge clk) begin
    if (cnt_clr_o) n_clr++;
    if (cnt_inc_o) n_inc++;
    if (res_stb_o) n_stb++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) num_i = ~num_i;
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_stb(output int l);
    l = 0;
    while (l < 60) begin
      tick();
      l++;
      if (res_stb_o) break;
    end
  endtask
  task automatic base();
    b_clr = n_clr;
    b_inc = n_inc;
    b_stb = n_stb;
  endtask
  task automatic kick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask
  initial begin
    #1;
    chk("rst_state", 16'(state_o), 16'd0);
    chk("rst_busy", 16'(busy_o), 16'd0);
    chk("rst_res", 16'(res_bcd_o), 16'h000);
    chk("rst_of", 16'(res_of_o), 16'd0);
    chk("rst_stb", 16'(res_stb_o), 16'd0);
    chk("rst_clr", 16'(cnt_clr_o), 16'd0);
    #20 rst = 1'b0;
    ticks(2);
    tog = 1'b1;
    base();
    kick();
    chk("t1_clear_state", 16'(state_o), 16'd1);
    chk("t1_clear_pulse", 16'(cnt_clr_o), 16'd1);
    wait_stb(lat);
    chk("t1_latency", 16'(lat), 16'd23);
    ticks(3);
    chk("t1_n_clr", 16'(n_clr - b_clr), 16'd1);
    chk("t1_n_inc", 16'(n_inc - b_inc), 16'd10);
    chk("t1_n_stb", 16'(n_stb - b_stb), 16'd1);
    chk("t1_res", 16'(res_bcd_o), 16'h010);
    chk("t1_of", 16'(res_of_o), 16'd0);
    chk("t1_busy", 16'(busy_o), 16'd0);
    tog = 1'b0;
    num_i = 1'b1;
    ticks(2);
    base();
    kick();
    wait_stb(lat);
    chk("t2_latency", 16'(lat), 16'd23);
    ticks(2);
    chk("t2_n_inc", 16'(n_inc - b_inc), 16'd0);
    chk("t2_res", 16'(res_bcd_o), 16'h000);
    chk("t2_n_stb", 16'(n_stb - b_stb), 16'd1);
    tog = 1'b1;
    cont_i = 1'b1;
    kick();
    wait_stb(lat);
    chk("t3_first_lat", 16'(lat), 16'd23);
    chk("t3_res1", 16'(res_bcd_o), 16'h010);
    chk("t3_hold_state", 16'(state_o), 16'd5);
    wait_stb(lat);
    chk("t3_period", 16'(lat), 16'd28);
    chk("t3_res2", 16'(res_bcd_o), 16'h010);
    cont_i = 1'b0;
    base();
    ticks(10);
    chk("t3_idle", 16'(state_o), 16'd0);
    chk("t3_no_clear", 16'(n_clr - b_clr), 16'd0);
    chk("t3_busy", 16'(busy_o), 16'd0);
    tog = 1'b0;
    num_i = 1'b0;
    tick();
    base();
    kick();
    ticks(8);
    chk("t4_gate", 16'(state_o), 16'd2);
    abort_i = 1'b1;
    num_i = 1'b1;
    chk("t4_inc_masked", 16'(cnt_inc_o), 16'd0);
    tick();
    abort_i = 1'b0;
    chk("t4_idle", 16'(state_o), 16'd0);
    tog = 1'b1;
    ticks(30);
    chk("t4_n_inc", 16'(n_inc - b_inc), 16'd0);
    chk("t4_n_stb", 16'(n_stb - b_stb), 16'd0);
    chk("t4_res_kept", 16'(res_bcd_o), 16'h010);
    kick();
    ticks(6);
    of_force = 1'b1;
    tick();
`ifdef GATE_OVF_STOP_EN
    chk("t5_settle", 16'(state_o), 16'd3);
    wait_stb(lat);
    chk("t5_lat", 16'(lat), 16'd2);
`else
    chk("t5_still_gate", 16'(state_o), 16'd2);
    wait_stb(lat);
    chk("t5_lat", 16'(lat), 16'd16);
`endif
    chk("t5_of", 16'(res_of_o), 16'd1);
    of_force = 1'b0;
    ticks(10);
    chk("t5_busy", 16'(busy_o), 16'd0);
    kick();
    ticks(6);
    chk("t6_gate", 16'(state_o), 16'd2);
    rst = 1'b1;
    #1;
    chk("t6_state", 16'(state_o), 16'd0);
    chk("t6_busy", 16'(busy_o), 16'd0);
    chk("t6_res", 16'(res_bcd_o), 16'h000);
    chk("t6_of", 16'(res_of_o), 16'd0);
    chk("t6_inc", 16'(cnt_inc_o), 16'd0);
    chk("t6_clr", 16'(cnt_clr_o), 16'd0);
    #10 rst = 1'b0;
    tick();
    base();
    kick();
    wait_stb(lat);
    chk("t6_lat", 16'(lat), 16'd23);
    chk("t6_fresh_res", 16'(res_bcd_o), 16'h010);
    chk("t6_fresh_of", 16'(res_of_o), 16'd0);
    chk("t6_n_inc", 16'(n_inc - b_inc), 16'd10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
